// File: rtl/demux_rr_scheduler.sv
// Round-robin 1-to-8 demultiplexer: each accepted data bit is driven onto the next
// enabled output line for DWELL cycles, then the block returns to IDLE for a new grant.
module demux_rr_scheduler #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    input  logic [7:0] ch_en,
    output logic [2:0] sel,
    output logic [7:0] y,
    output logic       busy
);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       dbit, dbit_nxt;
    logic [2:0] last, last_nxt;
    logic [2:0] sel_nxt;
    logic [7:0] y_nxt;
    logic       busy_nxt;
    logic [2:0] grant;
    logic [2:0] idx;
    logic       found;
    logic       xfer;

    assign in_ready = (state == IDLE) && (|ch_en);
    assign xfer     = in_valid && in_ready;

    // Search starts just after the previous grant and ends on it, so a lone channel repeats.
    always_comb begin
        grant = last;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last + 3'(i);
            if (!found && ch_en[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = DRIVE;
            DRIVE:   if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; ch_en and in_data only matter at a transfer.
    always_comb begin
        sel_nxt  = sel;
        y_nxt    = y;
        busy_nxt = busy;
        cnt_nxt  = cnt;
        dbit_nxt = dbit;
        last_nxt = last;
        case (state)
            IDLE: begin
                y_nxt    = 8'h00;
                busy_nxt = 1'b0;
                if (xfer) begin
                    sel_nxt  = grant;
                    dbit_nxt = in_data;
                    y_nxt    = 8'(in_data) << grant;
                    busy_nxt = 1'b1;
                    cnt_nxt  = 4'(DWELL - 1);
                end
            end
            DRIVE: begin
                if (cnt == 4'd0) begin
                    y_nxt    = 8'h00;
                    busy_nxt = 1'b0;
                    last_nxt = sel;
                end else begin
                    y_nxt    = 8'(dbit) << sel;
                    busy_nxt = 1'b1;
                    cnt_nxt  = cnt - 4'd1;
                end
            end
            default: begin
                y_nxt    = 8'h00;
                busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= 3'd0;
            y    <= 8'h00;
            busy <= 1'b0;
            cnt  <= 4'd0;
            dbit <= 1'b0;
            last <= 3'd7;
        end else begin
            sel  <= sel_nxt;
            y    <= y_nxt;
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
            dbit <= dbit_nxt;
            last <= last_nxt;
        end
    end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Scoreboard bench for demux_rr_scheduler: a DWELL=2 instance and a DWELL=1 instance,
// expected grants queued by directed stimulus and checked by a negedge monitor.
module tb_demux_rr_scheduler;

    typedef struct {
        int         inst;
        logic [2:0] s;
        logic [7:0] y;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid1, in_data1, in_ready1, busy1;
    logic [7:0] ch_en1, y1;
    logic [2:0] sel1;
    logic       in_valid2, in_data2, in_ready2, busy2;
    logic [7:0] ch_en2, y2;
    logic [2:0] sel2;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic       pb[2];
    int         run[2];
    logic [2:0] cur_sel[2];
    logic [7:0] cur_y[2];
    logic [2:0] hold[2];

    demux_rr_scheduler #(.DWELL(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .ch_en(ch_en1), .sel(sel1), .y(y1), .busy(busy1)
    );

    demux_rr_scheduler #(.DWELL(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .ch_en(ch_en2), .sel(sel2), .y(y2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dw(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic push(input int k, input logic [2:0] s, input logic [7:0] yy);
        exp_t e;
        e.inst = k;
        e.s    = s;
        e.y    = yy;
        q.push_back(e);
    endtask

    task automatic mon(input int k, input logic b, input logic [2:0] s, input logic [7:0] yy);
        exp_t e;
        if (!rst_n) begin
            pb[k]   = 1'b0;
            run[k]  = 0;
            hold[k] = 3'd0;
            return;
        end
        if (b) begin
            if (!pb[k]) begin
                run[k] = 0;
                if (q.size() == 0) begin
                    chk("unexpected_grant", 32'(s), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("grant_inst", k, e.inst);
                    cur_sel[k] = e.s;
                    cur_y[k]   = e.y;
                end
            end
            run[k]++;
            chk("drive_sel", 32'(s), 32'(cur_sel[k]));
            chk("drive_y", 32'(yy), 32'(cur_y[k]));
            hold[k] = cur_sel[k];
        end else begin
            if (pb[k]) chk("dwell_len", run[k], dw(k));
            chk("idle_y", 32'(yy), 32'h0);
            chk("idle_sel_hold", 32'(s), 32'(hold[k]));
        end
        pb[k] = b;
    endtask

    always @(negedge clk) begin
        mon(0, busy1, sel1, y1);
        mon(1, busy2, sel2, y2);
    end

    // Hold in_valid until n grants have completed; with a stable enable mask the
    // n-th grant must end exactly n*(DWELL+1) negedges after the start.
    task automatic run_grants(input int k, input int n, input bit toggle);
        int   cyc;
        int   done;
        logic pbl;
        logic b;
        cyc  = 0;
        done = 0;
        pbl  = 1'b0;
        if (k == 0) in_valid1 = 1'b1; else in_valid2 = 1'b1;
        while (done < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            b = (k == 0) ? busy1 : busy2;
            if (b && !pbl && toggle) in_data2 = ~in_data2;
            if (!b && pbl) done++;
            pbl = b;
        end
        if (k == 0) in_valid1 = 1'b0; else in_valid2 = 1'b0;
        chk("grant_spacing", cyc, n * (dw(k) + 1));
    endtask

    task automatic wait_busy1(input logic level);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busy1 !== level && cyc < 50);
        chk("wait_busy", 32'(busy1), 32'(level));
    endtask

    initial begin
        in_valid1 = 1'b0; in_data1 = 1'b0; ch_en1 = 8'h00;
        in_valid2 = 1'b0; in_data2 = 1'b0; ch_en2 = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_y", 32'(y1), 32'h0);
        chk("rst_sel", 32'(sel1), 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_in_ready", 32'(in_ready1), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Full mask: rotate through every channel and wrap back to 0.
        @(negedge clk);
        ch_en1 = 8'hFF; in_data1 = 1'b1;
        for (int i = 0; i < 9; i++) push(0, 3'(i % 8), 8'h01 << (i % 8));
        run_grants(0, 9, 1'b0);

        // Two enabled channels alternate, starting after the previous grant (0).
        ch_en1 = 8'b0010_0100;
        push(0, 3'd2, 8'h04); push(0, 3'd5, 8'h20);
        push(0, 3'd2, 8'h04); push(0, 3'd5, 8'h20);
        run_grants(0, 4, 1'b0);

        // Empty mask blocks all transfers despite in_valid.
        ch_en1 = 8'h00; in_valid1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("empty_in_ready", 32'(in_ready1), 32'h0);
            chk("empty_busy", 32'(busy1), 32'h0);
        end
        ch_en1 = 8'h80;
        push(0, 3'd7, 8'h80);
        run_grants(0, 1, 1'b0);

        // Mask and data drop mid-grant must not disturb the grant in progress.
        ch_en1 = 8'h08; in_data1 = 1'b1;
        push(0, 3'd3, 8'h08);
        in_valid1 = 1'b1;
        wait_busy1(1'b1);
        ch_en1 = 8'h00; in_data1 = 1'b0;
        wait_busy1(1'b0);
        chk("after_drop_in_ready", 32'(in_ready1), 32'h0);
        repeat (3) @(negedge clk);
        chk("after_drop_busy", 32'(busy1), 32'h0);
        in_valid1 = 1'b0;

        // Asynchronous reset in the second DRIVE cycle discards the grant.
        ch_en1 = 8'h10; in_data1 = 1'b1;
        push(0, 3'd4, 8'h10);
        in_valid1 = 1'b1;
        wait_busy1(1'b1);
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("pre_rst_sel", 32'(sel1), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_y", 32'(y1), 32'h0);
        chk("async_rst_sel", 32'(sel1), 32'h0);
        chk("async_rst_busy", 32'(busy1), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        ch_en1 = 8'hFF;
        push(0, 3'd0, 8'h01);
        run_grants(0, 1, 1'b0);

        // DWELL=1 instance, single channel, data toggling per transfer.
        ch_en2 = 8'h01; in_data2 = 1'b1;
        push(1, 3'd0, 8'h01); push(1, 3'd0, 8'h00); push(1, 3'd0, 8'h01);
        run_grants(1, 3, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
